// File: rtl/sbp_pkg.sv
// Shared types for the lookup scheduler: head beat, FIFO entry, FSM state.
package sbp_pkg;

  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int RESULT_BITS   = 24;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    QUIET
  } state_t;

  typedef struct packed {
    logic                     update;
    logic [31:0]              ip_addr;
    logic [5:0]               bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } beat_t;

  typedef struct packed {
    logic [31:0]            addr;
    logic [RESULT_BITS-1:0] data;
  } res_t;

endpackage

// File: rtl/sbp_lookup_sched_if.sv
// Handshake, pipeline head/tail, quiesce and stats bundle of the scheduler.
interface sbp_lookup_sched_if;
  import sbp_pkg::*;

  logic                     lkp_valid_i;
  logic                     lkp_ready_o;
  logic [31:0]              lkp_addr_i;

  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_len_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_i;
  logic [LOCATION_BITS-1:0] upd_loc_i;
  logic [RESULT_BITS-1:0]   upd_data_i;

  logic                     pipe_update_o;
  logic [31:0]              pipe_ip_addr_o;
  logic [5:0]               pipe_bit_pos_o;
  logic [STAGE_ID_BITS-1:0] pipe_stage_id_o;
  logic [LOCATION_BITS-1:0] pipe_location_o;
  logic [RESULT_BITS-1:0]   pipe_result_o;

  logic [31:0]              pipe_ip_addr_i;
  logic [RESULT_BITS-1:0]   pipe_result_i;

  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [31:0]              res_addr_o;
  logic [RESULT_BITS-1:0]   res_data_o;

  logic                     quiesce_i;
  logic                     quiet_o;

  logic [31:0]              stat_lkp_o;
  logic [31:0]              stat_upd_o;
  logic [31:0]              stat_stall_o;

  modport slave (
    input  lkp_valid_i, lkp_addr_i,
    output lkp_ready_o,
    input  upd_valid_i, upd_prefix_i, upd_len_i,
    input  upd_stage_i, upd_loc_i, upd_data_i,
    output upd_ready_o,
    output pipe_update_o, pipe_ip_addr_o, pipe_bit_pos_o,
    output pipe_stage_id_o, pipe_location_o, pipe_result_o,
    input  pipe_ip_addr_i, pipe_result_i,
    output res_valid_o, res_addr_o, res_data_o,
    input  res_ready_i,
    input  quiesce_i,
    output quiet_o,
    output stat_lkp_o, stat_upd_o, stat_stall_o
  );

  modport master (
    output lkp_valid_i, lkp_addr_i,
    input  lkp_ready_o,
    output upd_valid_i, upd_prefix_i, upd_len_i,
    output upd_stage_i, upd_loc_i, upd_data_i,
    input  upd_ready_o,
    input  pipe_update_o, pipe_ip_addr_o, pipe_bit_pos_o,
    input  pipe_stage_id_o, pipe_location_o, pipe_result_o,
    output pipe_ip_addr_i, pipe_result_i,
    input  res_valid_o, res_addr_o, res_data_o,
    output res_ready_i,
    output quiesce_i,
    input  quiet_o,
    input  stat_lkp_o, stat_upd_o, stat_stall_o
  );

endinterface

// File: rtl/sbp_sync_fifo.sv
// Synchronous FIFO, first word falls through from the register array.
module sbp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  assign valid  = count != '0;
  assign do_pop = pop && valid;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sbp_lookup_sched.sv
// Lookup/update scheduler at the head of the lookup chain.
// Define SBP_SCHED_STATS_EN to build the grant/stall counters.
module sbp_lookup_sched
  import sbp_pkg::*;
#(
  parameter int NUM_STAGES  = 24,
  parameter int ROOT_STAGE  = 1,
  parameter int RES_DEPTH   = 8,
  parameter int MAX_UPD_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  sbp_lookup_sched_if.slave bus
);

  localparam int PIPE_LAT = 2 * NUM_STAGES;
  localparam int RUN_W    = $clog2(MAX_UPD_RUN + 1);
  localparam int CRD_W    = $clog2(RES_DEPTH + 1);

  state_t           state;
  state_t           state_n;
  logic             live;
  logic             quiet;
  logic [CRD_W-1:0] credit;
  logic [RUN_W-1:0] run_cnt;
  logic [PIPE_LAT:0] trk_vld;
  logic [PIPE_LAT:0] trk_lkp;
  beat_t            head;
  beat_t            beat_n;
  res_t             res_in;
  res_t             res_out;

  logic eligible;
  logic lkp_win;
  logic lkp_ready;
  logic upd_ready;
  logic lkp_grant;
  logic upd_grant;
  logic res_valid;
  logic res_pop;
  logic tail_push;
  logic inflight;

  // live keeps both readies low through reset and the first cycle after it
  assign eligible  = live && (state == RUN) && (credit != '0);
  assign lkp_win   = run_cnt == RUN_W'(MAX_UPD_RUN);
  assign lkp_ready = eligible && (!bus.upd_valid_i || lkp_win);
  assign upd_ready = live && !(bus.lkp_valid_i && eligible && lkp_win);
  assign lkp_grant = bus.lkp_valid_i && lkp_ready;
  assign upd_grant = bus.upd_valid_i && upd_ready;

  assign bus.lkp_ready_o = lkp_ready;
  assign bus.upd_ready_o = upd_ready;

  always_comb begin
    beat_n = '0;
    unique case (1'b1)
      upd_grant: begin
        beat_n.update   = 1'b1;
        beat_n.ip_addr  = bus.upd_prefix_i;
        beat_n.bit_pos  = bus.upd_len_i;
        beat_n.stage_id = bus.upd_stage_i;
        beat_n.location = bus.upd_loc_i;
        beat_n.result   = bus.upd_data_i;
      end
      lkp_grant: begin
        beat_n.ip_addr  = bus.lkp_addr_i;
        beat_n.stage_id = STAGE_ID_BITS'(ROOT_STAGE);
      end
      default: beat_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      trk_vld <= '0;
      trk_lkp <= '0;
      live    <= 1'b0;
    end else begin
      head    <= beat_n;
      trk_vld <= {trk_vld[PIPE_LAT-1:0], lkp_grant | upd_grant};
      trk_lkp <= {trk_lkp[PIPE_LAT-1:0], lkp_grant};
      live    <= 1'b1;
    end
  end

  assign bus.pipe_update_o   = head.update;
  assign bus.pipe_ip_addr_o  = head.ip_addr;
  assign bus.pipe_bit_pos_o  = head.bit_pos;
  assign bus.pipe_stage_id_o = head.stage_id;
  assign bus.pipe_location_o = head.location;
  assign bus.pipe_result_o   = head.result;

  assign tail_push = trk_vld[PIPE_LAT] && trk_lkp[PIPE_LAT];
  assign inflight  = |(trk_vld & trk_lkp);
  assign res_pop   = res_valid && bus.res_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit  <= CRD_W'(RES_DEPTH);
      run_cnt <= '0;
    end else begin
      unique case ({lkp_grant, res_pop})
        2'b10:   credit <= credit - CRD_W'(1);
        2'b01:   credit <= credit + CRD_W'(1);
        default: credit <= credit;
      endcase
      if (!eligible || lkp_grant) run_cnt <= '0;
      else if (upd_grant && bus.lkp_valid_i)
        run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  // credit bounds FIFO occupancy, so the tail never needs backpressure
  assign res_in.addr = bus.pipe_ip_addr_i;
  assign res_in.data = bus.pipe_result_i;

  sbp_sync_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail_push),
    .din   (res_in),
    .pop   (res_pop),
    .dout  (res_out),
    .valid (res_valid)
  );

  assign bus.res_valid_o = res_valid;
  assign bus.res_addr_o  = res_out.addr;
  assign bus.res_data_o  = res_out.data;

  always_comb begin
    state_n = state;
    unique case (state)
      RUN: if (bus.quiesce_i) state_n = DRAIN;
      DRAIN: begin
        if (!bus.quiesce_i) state_n = RUN;
        else if (!inflight && !res_valid) state_n = QUIET;
      end
      QUIET: if (!bus.quiesce_i) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      quiet <= 1'b0;
    end else begin
      state <= state_n;
      quiet <= state_n == QUIET;
    end
  end

  assign bus.quiet_o = quiet;

`ifdef SBP_SCHED_STATS_EN
  logic [31:0] n_lkp;
  logic [31:0] n_upd;
  logic [31:0] n_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lkp   <= '0;
      n_upd   <= '0;
      n_stall <= '0;
    end else begin
      if (lkp_grant) n_lkp <= n_lkp + 32'd1;
      if (upd_grant) n_upd <= n_upd + 32'd1;
      if (bus.lkp_valid_i && !lkp_ready)
        n_stall <= n_stall + 32'd1;
    end
  end

  assign bus.stat_lkp_o   = n_lkp;
  assign bus.stat_upd_o   = n_upd;
  assign bus.stat_stall_o = n_stall;
`else
  assign bus.stat_lkp_o   = '0;
  assign bus.stat_upd_o   = '0;
  assign bus.stat_stall_o = '0;
`endif

endmodule
